seg7_scan_driver: RTL and testbench

//   Time-multiplexed N-digit seven-segment display driver; parametrised successor to the single-digit hex glyph decoder.

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 106 ++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the system datapath and the seven-segment scan driver.
// The master side supplies frame data and control; the slave side drives the pins.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  lz_en;
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic [7:0]            cathodes;
  logic [DIGITS-1:0]     anodes;
  logic                  frame_start;

  modport master (
    output enable, lz_en, load, value, dp_in,
    input  cathodes, anodes, frame_start
  );

  modport slave (
    input  enable, lz_en, load, value, dp_in,
    output cathodes, anodes, frame_start
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a double-buffered frame,
// guard blanking between digits, leading-zero suppression and frame-aligned commits.
module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 500
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);

  // Segment pattern in bits[7:1] (g..a); bit 0 is left for the decimal point.
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'h7E;
      4'h1:    seg = 8'h0C;
      4'h2:    seg = 8'hB6;
      4'h3:    seg = 8'h9E;
      4'h4:    seg = 8'hCC;
      4'h5:    seg = 8'hDA;
      4'h6:    seg = 8'hFA;
      4'h7:    seg = 8'h0E;
      4'h8:    seg = 8'hFE;
      4'h9:    seg = 8'hDE;
      4'hA:    seg = 8'hEE;
      4'hB:    seg = 8'hF8;
      4'hC:    seg = 8'hB0;
      4'hD:    seg = 8'hBC;
      4'hE:    seg = 8'hF2;
      4'hF:    seg = 8'hE2;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_act_value;
  logic [DIGITS-1:0]     r_act_dp;
  logic [4*DIGITS-1:0]   r_pend_value;
  logic [DIGITS-1:0]     r_pend_dp;
  logic                  r_pend_vld;
  logic [DIGITS-1:0]     r_anodes;
  logic [7:0]            r_cathodes;
  logic                  r_frame_start;

  logic                  w_frame_cycle;
  logic                  w_commit;
  logic [4*DIGITS-1:0]   w_cur_value;
  logic [DIGITS-1:0]     w_cur_dp;
  logic [3:0]            w_nib;
  logic                  w_blank;
  logic [7:0]            w_glyph;
  logic [DIGITS-1:0]     w_anodes_nxt;
  logic [7:0]            w_cathodes_nxt;

  assign w_frame_cycle = (r_presc == '0) && (r_idx == '0);
  assign w_commit      = w_frame_cycle && r_pend_vld;

  // Digit decode; a committing frame is shown from its first cycle, so no stale digit leaks.
  always_comb begin
    w_cur_value    = r_act_value;
    w_cur_dp       = r_act_dp;
    w_nib          = 4'h0;
    w_blank        = 1'b0;
    w_glyph        = 8'h00;
    w_anodes_nxt   = '1;
    w_cathodes_nxt = 8'h00;
    if (w_commit) begin
      w_cur_value = r_pend_value;
      w_cur_dp    = r_pend_dp;
    end else begin
      w_cur_value = r_act_value;
      w_cur_dp    = r_act_dp;
    end
    w_nib   = w_cur_value[{r_idx, 2'b00} +: 4];
    w_blank = bus.lz_en && (r_idx != '0) && ((w_cur_value >> {r_idx, 2'b00}) == '0);
    w_glyph = w_blank ? 8'h00 : glyph(w_nib);
    if (!bus.enable || (r_presc < GUARD_END)) begin
      w_anodes_nxt   = '1;
      w_cathodes_nxt = 8'h00;
    end else begin
      w_anodes_nxt[r_idx] = 1'b0;
      w_cathodes_nxt      = {w_glyph[7:1], w_cur_dp[r_idx]};
    end
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Pending/active frame buffers; a load in the commit cycle stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_vld   <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
    end else begin
      if (bus.load) begin
        r_pend_value <= bus.value;
        r_pend_dp    <= bus.dp_in;
        r_pend_vld   <= 1'b1;
      end else if (w_commit) begin
        r_pend_vld   <= 1'b0;
      end
      if (w_commit) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anodes      <= '1;
      r_cathodes    <= 8'h00;
      r_frame_start <= 1'b0;
    end else begin
      r_anodes      <= w_anodes_nxt;
      r_cathodes    <= w_cathodes_nxt;
      r_frame_start <= w_frame_cycle;
    end
  end

  assign bus.anodes      = r_anodes;
  assign bus.cathodes    = r_cathodes;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, DIV=8, GUARD=2): walks whole
// frames cycle by cycle against hand-computed glyphs per digit.
module tb_seg7_scan_driver;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   en_left;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(.DIGITS(4), .DIV(8), .GUARD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame (or its first n cycles). g = {digit3,digit2,digit1,digit0} expected cathodes.
  // Loads are driven after cycle la1/la2; enable is dropped for 20 cycles after cycle en_off.
  task automatic run_frame(input int fr, input int n, input logic [31:0] g,
                           input int la1, input logic [15:0] v1,
                           input int la2, input logic [15:0] v2,
                           input logic [3:0] dp, input int en_off);
    logic [3:0] exp_an;
    logic [7:0] exp_ca;
    bit         guard;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      guard  = ((k % 8) < 2) || !bus.enable;
      exp_an = guard ? 4'hF : ~(4'b0001 << (k / 8));
      exp_ca = guard ? 8'h00 : g[(k / 8) * 8 +: 8];
      chk($sformatf("f%0d.k%0d.anodes", fr, k), {28'd0, bus.anodes}, {28'd0, exp_an});
      chk($sformatf("f%0d.k%0d.cathodes", fr, k), {24'd0, bus.cathodes}, {24'd0, exp_ca});
      chk($sformatf("f%0d.k%0d.frame_start", fr, k), {31'd0, bus.frame_start},
          {31'd0, (k == 0)});
      bus.load = 1'b0;
      if (k == la1) begin
        bus.load = 1'b1; bus.value = v1; bus.dp_in = dp;
      end
      if (k == la2) begin
        bus.load = 1'b1; bus.value = v2; bus.dp_in = dp;
      end
      if (k == en_off) begin
        en_left = 20; bus.enable = 1'b0;
      end else if (en_left > 0) begin
        en_left--;
        if (en_left == 0) bus.enable = 1'b1;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; en_left = 0;
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.lz_en = 1'b0; bus.load = 1'b0;
    bus.value = 16'h0000; bus.dp_in = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset.anodes", {28'd0, bus.anodes}, 32'h0000_000F);
    chk("reset.cathodes", {24'd0, bus.cathodes}, 32'h0000_0000);
    chk("reset.frame_start", {31'd0, bus.frame_start}, 32'h0000_0000);
    rst_n = 1'b1;

    // Blank frame, load mid-frame must not show yet.
    run_frame(1, 32, 32'h7E7E_7E7E, 10, 16'h12AF, -1, 16'h0000, 4'b0001, -1);
    // 12AF with dp0; two loads, last wins.
    run_frame(2, 32, 32'h0CB6_EEE3, 5, 16'h1111, 20, 16'h2222, 4'b0000, -1);
    // 2222; AAAA pending, then a load exactly in the commit cycle.
    run_frame(3, 32, 32'hB6B6_B6B6, 10, 16'hAAAA, 31, 16'h0050, 4'b0000, -1);
    bus.lz_en = 1'b1;
    run_frame(4, 32, 32'hEEEE_EEEE, -1, 16'h0000, -1, 16'h0000, 4'b0000, -1);
    // Leading-zero suppression of 0050.
    run_frame(5, 32, 32'h0000_DA7E, 3, 16'h0000, -1, 16'h0000, 4'b1000, -1);
    // Zero with dp on blanked digit 3.
    run_frame(6, 32, 32'h0100_007E, 3, 16'h0000, -1, 16'h0000, 4'b0000, -1);
    run_frame(7, 32, 32'h0000_007E, -1, 16'h0000, -1, 16'h0000, 4'b0000, -1);
    bus.lz_en = 1'b0;
    // Enable low for 20 cycles across a frame boundary.
    run_frame(8, 32, 32'h7E7E_7E7E, -1, 16'h0000, -1, 16'h0000, 4'b0000, 20);
    run_frame(9, 32, 32'h7E7E_7E7E, 12, 16'h12AF, -1, 16'h0000, 4'b0001, -1);
    // Stop inside digit 2's lit window, then reset asynchronously.
    run_frame(10, 20, 32'h0CB6_EEE3, -1, 16'h0000, -1, 16'h0000, 4'b0000, -1);
    rst_n = 1'b0;
    #1;
    chk("midreset.anodes", {28'd0, bus.anodes}, 32'h0000_000F);
    chk("midreset.cathodes", {24'd0, bus.cathodes}, 32'h0000_0000);
    chk("midreset.frame_start", {31'd0, bus.frame_start}, 32'h0000_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(11, 32, 32'h7E7E_7E7E, -1, 16'h0000, -1, 16'h0000, 4'b0000, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
